mem_access_unit: RTL and testbench

//  Memory-side stage of the multicycle CPU: consumes memRead/memWrite/IorD/IRWrite from the control FSM.

---
 rtl/mcpu_pkg.sv | 21 ++
 rtl/mem_timeout_ctr.sv | 27 ++
 rtl/mem_access_unit.sv | 125 ++++++++++++
 tb/tb_mem_access_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared state encoding and opcode constants for the multicycle CPU
package mcpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b100000;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - WAIT-cycle counter that flags when a memory transaction has waited LIMIT cycles
module mem_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // expired is asserted during the LIMIT-th enabled cycle so the abort lands on that edge
  assign expired = enable && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-side stage: req/ack transactions, IR/MDR capture; MEM_TIMEOUT_EN adds WAIT timeout
module mem_access_unit
  import mcpu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       ir,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              done,
  output logic              err
);

  mau_state_t state, next_state;
  logic       dest_ir;
  logic       expired;
  logic       accept;
  logic       capture;

  assign accept  = (state == IDLE) && (memRead || memWrite);
  assign capture = (state == WAIT) && mem_ack && !mem_we;
  assign opcode  = ir[31:26];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (memRead || memWrite) next_state = WAIT;
      WAIT:    if (mem_ack || expired)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs come straight from flops so the control FSM sees no input-to-output path
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req <= 1'b0;
      stall   <= 1'b0;
      done    <= 1'b0;
    end else begin
      mem_req <= (next_state == WAIT);
      stall   <= (next_state == WAIT);
      done    <= (next_state == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      dest_ir   <= 1'b0;
    end else if (accept) begin
      mem_addr  <= IorD ? alu_out : pc;
      mem_wdata <= wr_data;
      mem_we    <= memWrite;
      dest_ir   <= IRWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir  <= '0;
      mdr <= '0;
    end else if (capture) begin
      if (dest_ir) begin
        ir <= mem_rdata[31:0];
      end else begin
        mdr <= mem_rdata;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != WAIT),
    .enable  ((state == WAIT) && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((state == WAIT) && expired) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  import mcpu_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, memRead, memWrite, IorD, IRWrite, mem_ack;
  logic [31:0] pc, alu_out, wr_data, mem_rdata;
  logic        mem_req, mem_we, stall, done, err;
  logic [31:0] mem_addr, mem_wdata, ir, mdr;
  logic [5:0]  opcode;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  logic [31:0] m_ir = '0;
  logic [31:0] m_mdr = '0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .pc        (pc),
    .alu_out   (alu_out),
    .wr_data   (wr_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ir        (ir),
    .opcode    (opcode),
    .mdr       (mdr),
    .stall     (stall),
    .done      (done),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ack_after < 0 means never acknowledge (timeout path)
  task automatic txn(input logic rd, input logic wr, input logic iord, input logic irw,
                     input logic [31:0] a_pc, input logic [31:0] a_alu, input logic [31:0] wd,
                     input int ack_after, input logic [31:0] rdata, input int exp_stall);
    exp_t e;
    exp_t got_e;
    int   stall_cnt;
    logic got;
    e.addr  = iord ? a_alu : a_pc;
    e.we    = wr;
    e.wdata = wd;
    e.ir    = m_ir;
    e.mdr   = m_mdr;
    if (rd && !wr && ack_after >= 0) begin
      if (irw) e.ir = rdata;
      else     e.mdr = rdata;
    end
    m_ir  = e.ir;
    m_mdr = e.mdr;
    sb.push_back(e);

    memRead = rd; memWrite = wr; IorD = iord; IRWrite = irw;
    pc = a_pc; alu_out = a_alu; wr_data = wd;
    tick();
    memRead = 1'b0; memWrite = 1'b0;
    pc = ~a_pc; alu_out = ~a_alu; wr_data = ~wd; IorD = ~iord; IRWrite = ~irw;
    check("req_rise", mem_req, 1'b1);
    check("we_latch", mem_we, e.we);
    check("wdata_latch", mem_wdata, e.wdata);

    stall_cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      if (stall) stall_cnt++;
      check("addr_hold", mem_addr, e.addr);
      if (c == ack_after) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1'b1);
    check("stall_off", stall, 1'b0);
    check("req_off", mem_req, 1'b0);
    check("stall_cycles", stall_cnt, exp_stall);
    if (sb.size() > 0) begin
      got_e = sb.pop_front();
      check("ir", ir, got_e.ir);
      check("mdr", mdr, got_e.mdr);
    end
    tick();
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
    mem_ack = 1'b0; pc = '0; alu_out = '0; wr_data = '0; mem_rdata = '0;
    tick();
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ir", ir, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Fetch: ack after two WAIT cycles
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h40, 32'h0, 2, 32'h2000_0004, 3);
    check("fetch_opcode", opcode, OP_LW);

    // Load: ack in first WAIT cycle
    txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h40, 32'h0, 0, 32'hDEAD_BEEF, 1);

    // Store with simultaneous read request: write wins
    txn(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h80, 32'h55AA, 1, 32'h1234_5678, 2);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("stray_done", done, 1'b0);
    check("stray_stall", stall, 1'b0);
    tick();
    check("stray_ir", ir, m_ir);
    check("stray_mdr", mdr, m_mdr);

`ifdef MEM_TIMEOUT_EN
    txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h44, 32'h0, -1, 32'h0, 4);
    check("timeout_err", err, 1'b1);
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 32'h44, 32'h0, 0, 32'h0000_0002, 1);
    check("err_sticky", err, 1'b1);
`else
    txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h44, 32'h0, 10, 32'h0BAD_F00D, 11);
    check("no_timeout_err", err, 1'b0);
`endif

    // Reset in third WAIT cycle, then a late ack must be ignored
    memRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h20;
    tick();
    memRead = 1'b0;
    check("rw_req", mem_req, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ir = '0;
    m_mdr = '0;
    check("rw_req_clr", mem_req, 1'b0);
    check("rw_stall_clr", stall, 1'b0);
    check("rw_ir_clr", ir, m_ir);
    check("rw_mdr_clr", mdr, m_mdr);
    check("rw_err_clr", err, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("late_ack_done", done, 1'b0);
    check("late_ack_ir", ir, m_ir);
    check("late_ack_mdr", mdr, m_mdr);
    tick();
    check("late_ack_done2", done, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
